// File: rtl/lcplc_bit_unpacker.sv
// Word-to-field bitstream unpacker: buffers MSB-first packed words in a 2-word
// left-aligned bit buffer and serves variable-width right-aligned fields.
module lcplc_bit_unpacker #(
  parameter int WORD_WIDTH_LOG = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<WORD_WIDTH_LOG)-1:0] input_data,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic                      input_last,
  input  logic [WORD_WIDTH_LOG:0]   output_width,
  input  logic                      output_ready,
  output logic                      output_valid,
  output logic [(1<<WORD_WIDTH_LOG)-1:0] output_data,
  input  logic                      flush,
  output logic [WORD_WIDTH_LOG+1:0] bits_available,
  output logic                      stream_end
);

  localparam int W  = 1 << WORD_WIDTH_LOG;
  localparam int OW = WORD_WIDTH_LOG + 1;
  localparam int CW = WORD_WIDTH_LOG + 2;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state, state_next;
  logic [2*W-1:0]  bit_buf, buf_next;
  logic [CW-1:0]   occ, occ_next, occ_after_rd;
  logic [OW-1:0]   width_sat;
  logic            rd_fire, wr_fire;

  // Out-of-range widths are clamped to a full word rather than over-reading.
  always_comb begin
    width_sat = output_width;
    if (output_width > OW'(W)) width_sat = OW'(W);
  end

  assign input_ready    = rst && (state == FILL) && (occ <= CW'(W)) && !flush;
  assign output_valid   = rst && (occ >= CW'(width_sat)) && !flush;
  assign output_data    = rst ? (bit_buf[2*W-1:W] >> (OW'(W) - width_sat)) : '0;
  assign bits_available = occ;
  assign stream_end     = (state == DRAIN);

  assign rd_fire = output_valid && output_ready;
  assign wr_fire = input_valid && input_ready;

  // Read shift happens first so a same-cycle word lands right behind the
  // bits that survive the read.
  always_comb begin
    occ_after_rd = occ;
    buf_next     = bit_buf;
    if (rd_fire) begin
      occ_after_rd = occ - CW'(width_sat);
      buf_next     = bit_buf << width_sat;
    end
    occ_next = occ_after_rd;
    if (wr_fire) begin
      buf_next = buf_next | ({input_data, {W{1'b0}}} >> occ_after_rd);
      occ_next = occ_after_rd + CW'(W);
    end
  end

  always_comb begin
    state_next = state;
    if (flush)
      state_next = FILL;
    else if (wr_fire && input_last)
      state_next = DRAIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FILL;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_buf <= '0;
      occ     <= '0;
    end else if (flush) begin
      bit_buf <= '0;
      occ     <= '0;
    end else begin
      bit_buf <= buf_next;
      occ     <= occ_next;
    end
  end

endmodule

// File: tb/tb_lcplc_bit_unpacker.sv
// Bench for lcplc_bit_unpacker: directed scenarios plus a randomized run checked
// against a bit-queue reference model of the unpacker.
module tb_lcplc_bit_unpacker;

  localparam int WL = 5;
  localparam int W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_data;
  logic        input_valid, input_ready, input_last;
  logic [5:0]  output_width;
  logic        output_ready, output_valid;
  logic [31:0] output_data;
  logic        flush;
  logic [6:0]  bits_available;
  logic        stream_end;

  int n_checks = 0;
  int n_fail   = 0;

  bit mq[$];
  bit mdrain;
  bit m_last_in_ready, m_last_out_valid;

  lcplc_bit_unpacker #(.WORD_WIDTH_LOG(WL)) dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
    .input_last(input_last),
    .output_width(output_width), .output_ready(output_ready),
    .output_valid(output_valid), .output_data(output_data),
    .flush(flush), .bits_available(bits_available), .stream_end(stream_end)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] m_peek(int w);
    logic [31:0] v = '0;
    for (int i = 0; i < w; i++) v = {v[30:0], mq[i]};
    return v;
  endfunction

  task automatic idle();
    input_valid  = 1'b0;
    input_last   = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    output_width = '0;
    flush        = 1'b0;
  endtask

  // Advance one clock and apply the same transfers to the reference model.
  task automatic tick();
    bit rd, wr, lst;
    int w;
    logic [31:0] d;
    assert (output_width <= 6'(W));
    w   = int'(output_width);
    d   = input_data;
    lst = input_last;
    rd  = output_ready && !flush && (mq.size() >= w);
    wr  = input_valid && !flush && !mdrain && (mq.size() <= W);
    m_last_in_ready  = !flush && !mdrain && (mq.size() <= W);
    m_last_out_valid = !flush && (mq.size() >= w);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      mdrain = 1'b0;
    end else begin
      if (rd) for (int i = 0; i < w; i++) void'(mq.pop_front());
      if (wr) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
        if (lst) mdrain = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    mq.delete();
    mdrain = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic lst);
    input_valid = 1'b1;
    input_data  = d;
    input_last  = lst;
    #1;
    tick();
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    mq.delete();
    mdrain = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (input_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 0", input_ready); end
    n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b want 0", output_valid); end
    n_checks++; if (bits_available !== 7'd0) begin n_fail++; $display("[TB] FAIL rst_bits: got %0d want 0", bits_available); end
    n_checks++; if (stream_end !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stream_end: got %b want 0", stream_end); end
    n_checks++; if (output_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_out_data: got %h want 0", output_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in_ready: got %b want 1", input_ready); end
    n_checks++; if (output_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_valid_w0: got %b want 1", output_valid); end
    output_width = 6'd1;
    #1;
    n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_valid_w1: got %b want 0", output_valid); end
    output_width = 6'd0;
    @(negedge clk);
  endtask

  task automatic test_basic_split();
    int          widths [5] = '{4, 4, 8, 16, 32};
    logic [31:0] exp    [5] = '{32'hD, 32'hE, 32'hAD, 32'hBEEF, 32'h12345678};
    do_reset();
    write_word(32'hDEADBEEF, 1'b0);
    write_word(32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      output_width = 6'(widths[i]);
      output_ready = 1'b1;
      #1;
      n_checks++; if (output_valid !== 1'b1 || output_data !== exp[i]) begin n_fail++; $display("[TB] FAIL split_read%0d: got v=%b %h want v=1 %h", i, output_valid, output_data, exp[i]); end
      tick();
    end
    output_ready = 1'b0;
    #1;
    n_checks++; if (bits_available !== 7'd0) begin n_fail++; $display("[TB] FAIL split_occ_end: got %0d want 0", bits_available); end
  endtask

  task automatic test_straddle();
    int          widths [3] = '{12, 24, 28};
    logic [31:0] exp    [3] = '{32'hDEA, 32'hDBEEF1, 32'h2345678};
    do_reset();
    write_word(32'hDEADBEEF, 1'b0);
    write_word(32'h12345678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      output_width = 6'(widths[i]);
      output_ready = 1'b1;
      #1;
      n_checks++; if (output_valid !== 1'b1 || output_data !== exp[i]) begin n_fail++; $display("[TB] FAIL straddle_read%0d: got v=%b %h want v=1 %h", i, output_valid, output_data, exp[i]); end
      tick();
    end
    output_ready = 1'b0;
    #1;
    n_checks++; if (bits_available !== 7'd0) begin n_fail++; $display("[TB] FAIL straddle_occ_end: got %0d want 0", bits_available); end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_word(32'hDEADBEEF, 1'b0);
    write_word(32'h12345678, 1'b0);
    output_width = 6'd8;
    output_ready = 1'b1;
    #1;
    tick();
    output_ready = 1'b0;
    input_valid  = 1'b1;
    input_data   = 32'hCAFEBABE;
    #1;
    n_checks++; if (input_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_blocked: got %b want 0", input_ready); end
    n_checks++; if (bits_available !== 7'd56) begin n_fail++; $display("[TB] FAIL bp_occ56: got %0d want 56", bits_available); end
    tick();
    output_width = 6'd24;
    output_ready = 1'b1;
    #1;
    n_checks++; if (output_data !== 32'hADBEEF) begin n_fail++; $display("[TB] FAIL bp_read24: got %h want adbeef", output_data); end
    tick();
    output_ready = 1'b0;
    #1;
    n_checks++; if (input_ready !== 1'b1 || bits_available !== 7'd32) begin n_fail++; $display("[TB] FAIL bp_reopen: got rdy=%b occ=%0d want rdy=1 occ=32", input_ready, bits_available); end
    tick();
    input_valid  = 1'b0;
    output_width = 6'd32;
    output_ready = 1'b1;
    #1;
    n_checks++; if (output_data !== 32'h12345678) begin n_fail++; $display("[TB] FAIL bp_order1: got %h want 12345678", output_data); end
    tick();
    #1;
    n_checks++; if (output_valid !== 1'b1 || output_data !== 32'hCAFEBABE) begin n_fail++; $display("[TB] FAIL bp_order2: got v=%b %h want v=1 cafebabe", output_valid, output_data); end
    tick();
    output_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_word(32'hDEADBEEF, 1'b0);
    output_width = 6'd32;
    output_ready = 1'b1;
    input_valid  = 1'b1;
    input_data   = 32'hCAFEF00D;
    #1;
    n_checks++; if (output_data !== 32'hDEADBEEF || input_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_both: got %h rdy=%b want deadbeef rdy=1", output_data, input_ready); end
    tick();
    input_valid = 1'b0;
    #1;
    n_checks++; if (bits_available !== 7'd32) begin n_fail++; $display("[TB] FAIL sim_occ: got %0d want 32", bits_available); end
    n_checks++; if (output_data !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL sim_data: got %h want cafef00d", output_data); end
    tick();
    output_ready = 1'b0;
  endtask

  task automatic test_drain_flush();
    do_reset();
    write_word(32'hA5A5A5A5, 1'b1);
    #1;
    n_checks++; if (stream_end !== 1'b1 || input_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_enter: got end=%b rdy=%b want end=1 rdy=0", stream_end, input_ready); end
    output_width = 6'd8;
    output_ready = 1'b1;
    #1;
    n_checks++; if (output_data !== 32'hA5) begin n_fail++; $display("[TB] FAIL drain_read8: got %h want a5", output_data); end
    tick();
    output_width = 6'd32;
    #1;
    n_checks++; if (output_valid !== 1'b0 || bits_available !== 7'd24) begin n_fail++; $display("[TB] FAIL drain_short: got v=%b occ=%0d want v=0 occ=24", output_valid, bits_available); end
    tick();
    output_ready = 1'b0;
    output_width = 6'd0;
    flush        = 1'b1;
    #1;
    n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b want 0", output_valid); end
    tick();
    flush = 1'b0;
    #1;
    n_checks++; if (bits_available !== 7'd0 || stream_end !== 1'b0 || input_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_after: got occ=%0d end=%b rdy=%b want 0 0 1", bits_available, stream_end, input_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_word(32'hDEADBEEF, 1'b0);
    write_word(32'h12345678, 1'b0);
    output_width = 6'd24;
    output_ready = 1'b1;
    #1;
    tick();
    output_width = 6'd8;
    #1;
    n_checks++; if (bits_available !== 7'd40) begin n_fail++; $display("[TB] FAIL mid_occ40: got %0d want 40", bits_available); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({input_ready, output_valid, stream_end} !== 3'b000 || output_data !== 32'h0 || bits_available !== 7'd0) begin n_fail++; $display("[TB] FAIL mid_rst_outputs: got rdy=%b v=%b end=%b d=%h occ=%0d want all 0", input_ready, output_valid, stream_end, output_data, bits_available); end
    idle();
    mq.delete();
    mdrain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bits_available !== 7'd0 || stream_end !== 1'b0 || input_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_release: got occ=%0d end=%b rdy=%b want 0 0 1", bits_available, stream_end, input_ready); end
    write_word(32'h00000001, 1'b0);
    output_width = 6'd32;
    output_ready = 1'b1;
    #1;
    n_checks++; if (output_valid !== 1'b1 || output_data !== 32'h1) begin n_fail++; $display("[TB] FAIL mid_fresh: got v=%b %h want v=1 00000001", output_valid, output_data); end
    tick();
    output_ready = 1'b0;
  endtask

  task automatic test_random();
    bit hold_in, hold_out, prev_flush;
    int w;
    do_reset();
    m_last_in_ready  = 1'b1;
    m_last_out_valid = 1'b1;
    prev_flush = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      hold_in  = input_valid && !m_last_in_ready && !prev_flush;
      hold_out = output_ready && !m_last_out_valid && !prev_flush;
      if (!hold_in) begin
        input_valid = ($urandom_range(0, 3) != 0);
        input_data  = $urandom;
        input_last  = ($urandom_range(0, 39) == 0);
      end
      if (!hold_out) begin
        output_ready = ($urandom_range(0, 3) != 0);
        output_width = 6'($urandom_range(0, W));
      end
      flush = ($urandom_range(0, 29) == 0);
      prev_flush = flush;
      #1;
      w = int'(output_width);
      n_checks++; if (bits_available !== 7'(mq.size())) begin n_fail++; $display("[TB] FAIL rnd_occ cyc%0d: got %0d want %0d", cyc, bits_available, mq.size()); end
      n_checks++; if (output_valid !== (!flush && mq.size() >= w)) begin n_fail++; $display("[TB] FAIL rnd_valid cyc%0d: got %b want %b", cyc, output_valid, (!flush && mq.size() >= w)); end
      n_checks++; if (input_ready !== (!flush && !mdrain && mq.size() <= W)) begin n_fail++; $display("[TB] FAIL rnd_ready cyc%0d: got %b want %b", cyc, input_ready, (!flush && !mdrain && mq.size() <= W)); end
      n_checks++; if (stream_end !== mdrain) begin n_fail++; $display("[TB] FAIL rnd_end cyc%0d: got %b want %b", cyc, stream_end, mdrain); end
      if (mq.size() >= w) begin
        n_checks++; if (output_data !== m_peek(w)) begin n_fail++; $display("[TB] FAIL rnd_data cyc%0d w=%0d: got %h want %h", cyc, w, output_data, m_peek(w)); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    mdrain = 1'b0;
    test_reset();
    test_basic_split();
    test_straddle();
    test_backpressure();
    test_back_to_back();
    test_drain_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcplc_bit_unpacker.md
# lcplc_bit_unpacker

Word-to-field bitstream unpacker for the LCPLC decoder path. It accepts the packed 32-bit word stream that the LCPLC coder emits, MSB-first. It serves variable-width field reads (0..32 bits) to the downstream entropy decoder, one field per cycle. Internally it keeps a 2-word bit buffer with occupancy tracking, AXI-stream-style handshakes on both sides, and end-of-stream drain/flush handling.

## Interface
- WORD_WIDTH_LOG, 5, log2 of the word width W (W = 32 by default)
- clk  in  1  clock; all registers on the rising edge
- rst  in  1  reset, asynchronous, active-low
- input_data  in  W  packed stream word; first-transmitted bit is the MSB
- input_valid  in  1  input_data valid
- input_ready  out  1  unpacker can accept a word this cycle
- input_last  in  1  qualifies the final word of a coded stream
- output_width  in  WORD_WIDTH_LOG+1  number of bits requested (0..W)
- output_ready  in  1  consumer requests output_width bits this cycle
- output_valid  out  1  at least output_width bits are buffered
- output_data  out  W  requested field, right-aligned, upper bits zero
- flush  in  1  single-cycle pulse: discard all buffered bits and leave DRAIN
- bits_available  out  WORD_WIDTH_LOG+2  current buffer occupancy (0..2W)
- stream_end  out  1  high while in DRAIN

## Operation
- State: buffer buf[2W-1:0], left-aligned (the next bit to read is buf[2W-1]); occupancy occ in 0..2W; FSM {FILL, DRAIN}.
- input_ready = rst high && state==FILL && occ <= W && !flush.
- output_valid = rst high && occ >= output_width && !flush. Width 0 is always valid, returns 0 and consumes nothing.
- output_width > W is illegal. RTL saturates it to W; the bench asserts it never occurs.
- output_data = buf[2W-1 -: output_width] zero-extended; combinational from registered buf.
- Read transfer (output_valid && output_ready): buf <<= output_width; occ -= output_width.
- Write transfer (input_valid && input_ready): the word is ORed into buf at bit offset 2W-1-occ' (MSB-aligned directly after the remaining bits). occ' is occ after any same-cycle read. Then occ' += W.
- Simultaneous read and write in one cycle: both apply; the read shift happens before the insert. Max occ after update is 2W.
- FILL -> DRAIN: on a write transfer with input_last=1. In DRAIN, input_ready=0; reads continue until the consumer stops.
- DRAIN -> FILL: on flush only. Encoder padding bits are the consumer's responsibility and are discarded by flush.
- flush (either state): occ <- 0, buf <- 0, state <- FILL. No read or write transfer completes in a flush cycle.
- Arithmetic: occ is WORD_WIDTH_LOG+2 bits, unsigned; no wrap is possible given the guards above.

## Timing
- Async reset: while rst=0, buf=0, occ=0, state=FILL, and input_ready=0, output_valid=0, output_data=0, bits_available=0, stream_end=0, regardless of clk. These values apply immediately on assertion, including mid-transfer.
- First cycle after reset release: input_ready=1, output_valid=1 only if output_width=0.
- Latency: a word accepted at edge k is readable from the cycle after edge k (occ updated at k).
- Throughput: one word in plus one field out per cycle sustained.
- output_width and output_ready must be held stable while output_ready=1 and output_valid=0. output_valid may rise without output_ready.
- input_data, input_last and input_valid must be held while input_valid=1 and input_ready=0.

## Test plan
- Basic split: write 0xDEADBEEF, 0x12345678. Read widths 4,4,8,16,32 -> 0xD, 0xE, 0xAD, 0xBEEF, 0x12345678; occ ends 0.
- Straddle: same words. Read widths 12,24,28 -> 0xDEA, 0xDBEEF1, 0x2345678; the 24-bit read crosses the word boundary.
- Backpressure: after two writes and an 8-bit read (occ=56), input_ready=0 with input_valid held. Read 24 -> occ=32 -> input_ready=1 next cycle; the third word is accepted and data order is preserved.
- Simultaneous: at occ=32, read 32 and write 0xCAFEF00D in the same cycle -> occ stays 32; next 32-bit read returns 0xCAFEF00D.
- Drain/flush: write 0xA5A5A5A5 with input_last -> stream_end=1, input_ready=0. Read 8 -> 0xA5. Request 32 -> output_valid=0 (occ=24). Pulse flush -> occ=0, stream_end=0, input_ready=1.
- Reset mid-operation: with occ=40 and output_ready=1, pull rst low between edges -> all outputs 0 immediately. After release, occ=0, state FILL, and a fresh write of 0x00000001 then a 32-bit read returns 0x00000001.
